// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256 datapath: word width, schedule
//   window length, the message-schedule FSM state type and the small
//   sigma functions used by both the schedule expander and the round engine.
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int WIN_LEN = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2
    } sched_state_t;

    // Rotate right by a constant amount.
    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned       n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// sha256_w_expand
//   Combinational message-schedule expansion step:
//     w_new = sigma1(w14) + w9 + sigma0(w1) + w0   (mod 2^32)
//   Ports:
//     w14, w9, w1, w0 : window taps (w0 is the oldest word, W_{t-16})
//     w_new           : next schedule word W_t
module sha256_w_expand
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w14,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w0,
    output logic [WORD_W-1:0] w_new
);

    assign w_new = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   Loads a 512-bit block as 16 words over a valid/ready handshake, then
//   expands the 16-word sliding window on chip, streaming W_0..W_{ROUNDS-1}
//   one word per cycle (registered) to the round datapath.
//   Parameters:
//     ROUNDS : schedule words emitted per block (17..64)
//     CNT_W  : round-counter width, 2^CNT_W >= ROUNDS
//   Ports:
//     CLK, RST   : clock, asynchronous active-low reset
//     start      : begin a block (only honoured in IDLE)
//     abort      : synchronous return to IDLE, highest priority
//     word_valid, word_i, word_ready : input word handshake (ready only in LOAD)
//     w_o, w_valid, round_o : registered schedule word, its strobe and index
//     busy       : block in progress (LOAD or EXPAND)
//     done       : one-cycle pulse alongside the last word
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int CNT_W  = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_i,
    output logic              word_ready,
    output logic [WORD_W-1:0] w_o,
    output logic              w_valid,
    output logic [CNT_W-1:0]  round_o,
    output logic              busy,
    output logic              done
);

    sched_state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // win_reg[0] is the oldest word (W_{t-16}), win_reg[15] the newest.
    logic [WIN_LEN-1:0][WORD_W-1:0] win_reg;
    logic [WIN_LEN-1:0][WORD_W-1:0] win_shift;

    logic [WORD_W-1:0] w_o_reg;
    logic [CNT_W-1:0]  round_reg;
    logic              w_valid_reg;
    logic              done_reg;

    logic              accept;
    logic              emit_exp;
    logic              shift_en;
    logic              last_load;
    logic              last_word;
    logic [WORD_W-1:0] w_new;
    logic [WORD_W-1:0] shift_in;

    assign accept = (state_reg == LOAD) && word_valid;

    // After the last word the FSM stays in EXPAND for one more cycle (the
    // done cycle) without emitting, so busy covers the done cycle and a new
    // start cannot be taken until the cycle after done.
    assign emit_exp  = (state_reg == EXPAND) && !done_reg;
    assign shift_en  = !abort && (accept || emit_exp);
    assign last_load = accept && (cnt_reg == CNT_W'(WIN_LEN - 1));
    assign last_word = shift_en && emit_exp && (cnt_reg == CNT_W'(ROUNDS - 1));
    assign shift_in  = accept ? word_i : w_new;

    sha256_w_expand u_expand (
        .w14   (win_reg[14]),
        .w9    (win_reg[9]),
        .w1    (win_reg[1]),
        .w0    (win_reg[0]),
        .w_new (w_new)
    );

    // Shifted window: every slot takes its younger neighbour, the newest
    // slot takes the incoming word.
    for (genvar gi = 0; gi < WIN_LEN; gi++) begin : g_shift
        if (gi == WIN_LEN - 1) begin : g_head
            assign win_shift[gi] = shift_in;
        end else begin : g_body
            assign win_shift[gi] = win_reg[gi + 1];
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (last_load) begin
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                // Counter holds at ROUNDS-1 so it never wraps inside a block.
                if (emit_exp && !last_word) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (done_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            win_reg     <= '0;
            w_o_reg     <= '0;
            round_reg   <= '0;
            w_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            w_valid_reg <= shift_en;
            done_reg    <= last_word;
            if (shift_en) begin
                win_reg   <= win_shift;
                w_o_reg   <= shift_in;
                round_reg <= cnt_reg;
            end
        end
    end

    assign word_ready = (state_reg == LOAD);
    assign busy       = (state_reg != IDLE);
    assign w_o        = w_o_reg;
    assign w_valid    = w_valid_reg;
    assign round_o    = round_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule
//   Drives two schedule instances (ROUNDS=64 and ROUNDS=20) with directed
//   "abc" blocks and randomized blocks/gap patterns, and compares every
//   cycle against a timeline and a plain-array SHA-256 schedule model.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start64, start20;
    logic        abort;
    logic        word_valid;
    logic [31:0] word_i;

    logic        ready64, valid64, busy64, done64;
    logic [31:0] w64;
    logic [5:0]  round64;
    logic        ready20, valid20, busy20, done20;
    logic [31:0] w20;
    logic [4:0]  round20;

    sha256_msg_schedule #(.ROUNDS(64), .CNT_W(6)) dut64 (
        .CLK        (clk),
        .RST        (rst_n),
        .start      (start64),
        .abort      (abort),
        .word_valid (word_valid),
        .word_i     (word_i),
        .word_ready (ready64),
        .w_o        (w64),
        .w_valid    (valid64),
        .round_o    (round64),
        .busy       (busy64),
        .done       (done64)
    );

    sha256_msg_schedule #(.ROUNDS(20), .CNT_W(5)) dut20 (
        .CLK        (clk),
        .RST        (rst_n),
        .start      (start20),
        .abort      (abort),
        .word_valid (word_valid),
        .word_i     (word_i),
        .word_ready (ready20),
        .w_o        (w20),
        .w_valid    (valid20),
        .round_o    (round20),
        .busy       (busy20),
        .done       (done20)
    );

    // Outputs of the instance currently under test.
    logic        use20;
    logic        s_ready, s_valid, s_busy, s_done;
    logic [31:0] s_w;
    logic [5:0]  s_round;
    assign s_ready = use20 ? ready20 : ready64;
    assign s_valid = use20 ? valid20 : valid64;
    assign s_busy  = use20 ? busy20  : busy64;
    assign s_done  = use20 ? done20  : done64;
    assign s_w     = use20 ? w20     : w64;
    assign s_round = use20 ? {1'b0, round20} : round64;

    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_blk  = "init";
    int    cur_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s/%s cyc %0d: got %08h expected %08h",
                      cur_blk, tag, cur_cyc, got, exp);
    endtask

    // Reference model: textbook SHA-256 schedule recurrence over a flat array.
    logic [31:0] msg [16];
    logic [31:0] mw  [64];
    logic [31:0] got_w [64];

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void build_model();
        for (int t = 0; t < 16; t++) mw[t] = msg[t];
        for (int t = 16; t < 64; t++) begin
            logic [31:0] s0, s1;
            s0 = ror(mw[t-15], 7) ^ ror(mw[t-15], 18) ^ (mw[t-15] >> 3);
            s1 = ror(mw[t-2], 17) ^ ror(mw[t-2], 19) ^ (mw[t-2] >> 10);
            mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
        end
    endfunction

    function automatic void load_abc();
        msg[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) msg[i] = 32'h0;
        msg[15] = 32'h00000018;
        build_model();
    endfunction

    function automatic void load_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        build_model();
    endfunction

    // One block on the selected instance, relative cycle 0 = start cycle.
    // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random gaps.
    // junk_a/junk_b: extra start pulses (-1 none); abort_round: -1 none;
    // rst_cyc: assert reset after driving that cycle and return (-1 none).
    task automatic run_block(input string name, input bit sel20, input int gap_mode,
                             input int junk_a, input int junk_b,
                             input int abort_round, input int rst_cyc);
        int acc [16];
        int em  [64];
        int rounds, abort_cyc, last_cyc, n_words;
        bit ev, aborted, s;
        int eidx, ai;
        rounds  = sel20 ? 20 : 64;
        use20   = sel20;
        cur_blk = name;
        n_words = 0;
        for (int t = 0; t < 64; t++) got_w[t] = 32'h0;
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            acc[i] = ((i == 0) ? 1 : acc[i-1] + 1) + gap;
        end
        for (int t = 0; t < 64; t++)
            em[t] = (t < 16) ? acc[t] + 1 : acc[15] + 1 + (t - 15);
        abort_cyc = (abort_round >= 0) ? em[abort_round] : -1;
        last_cyc  = (abort_cyc >= 0) ? abort_cyc + 3 : em[rounds-1] + 3;

        for (int c = 0; c <= last_cyc; c++) begin
            @(negedge clk);
            cur_cyc = c;
            aborted = (abort_cyc >= 0) && (c > abort_cyc);
            ev = 1'b0;
            eidx = 0;
            for (int t = 0; t < rounds; t++)
                if (em[t] == c) begin ev = 1'b1; eidx = t; end
            if (aborted) ev = 1'b0;
            check("w_valid", 32'(s_valid), 32'(ev));
            check("busy",  32'(s_busy),  32'(!aborted && c >= 1 && c <= em[rounds-1]));
            check("ready", 32'(s_ready), 32'(!aborted && c >= 1 && c <= acc[15]));
            check("done",  32'(s_done),  32'(!aborted && c == em[rounds-1]));
            if (ev) begin
                check("round_o", 32'(s_round), 32'(eidx));
                check("w_o", s_w, mw[eidx]);
                got_w[eidx] = s_w;
                n_words++;
            end

            // Inputs for this cycle.
            ai = -1;
            for (int i = 0; i < 16; i++) if (acc[i] == c) ai = i;
            s = (c == 0) || (c == junk_a) || (c == junk_b);
            start64 = !sel20 && s;
            start20 = sel20 && s;
            abort   = (c == abort_cyc);
            if (ai >= 0) begin
                word_valid = 1'b1;
                word_i     = msg[ai];
            end else begin
                // Inside the load window gaps must be real gaps; elsewhere
                // word_valid is noise the design has to ignore.
                word_valid = (c >= 1 && c <= acc[15]) ? 1'b0 : 1'($urandom_range(0, 1));
                word_i     = $urandom;
            end

            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check("rst_w_o",     s_w,               32'h0);
                check("rst_round",   32'(s_round),      32'h0);
                check("rst_w_valid", 32'(s_valid),      32'h0);
                check("rst_busy",    32'(s_busy),       32'h0);
                check("rst_done",    32'(s_done),       32'h0);
                check("rst_ready",   32'(s_ready),      32'h0);
                break;
            end
        end
        start64 = 1'b0;
        start20 = 1'b0;
        abort   = 1'b0;
        word_valid = 1'b0;
        $display("block %-12s rounds=%0d gap_mode=%0d words_seen=%0d", name, rounds, gap_mode, n_words);
    endtask

    initial begin
        rst_n = 1'b0;
        start64 = 1'b0;
        start20 = 1'b0;
        abort = 1'b0;
        word_valid = 1'b0;
        word_i = 32'h0;
        use20 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cur_blk = "reset";
        check("w_o",     w64,           32'h0);
        check("w_valid", 32'(valid64),  32'h0);
        check("round_o", 32'(round64),  32'h0);
        check("busy",    32'(busy64),   32'h0);
        check("done",    32'(done64),   32'h0);
        check("ready",   32'(ready64),  32'h0);
        check("ready20", 32'(ready20),  32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        load_abc();
        run_block("abc_b2b", 1'b0, 0, -1, -1, -1, -1);
        cur_blk = "abc_consts";
        check("W16", got_w[16], 32'h61626380);
        check("W17", got_w[17], 32'h000F0000);
        check("W63", got_w[63], 32'h12B1EDEB);

        run_block("abc_gapped", 1'b0, 1, -1, -1, -1, -1);
        cur_blk = "gapped_consts";
        check("W16", got_w[16], 32'h61626380);
        check("W63", got_w[63], 32'h12B1EDEB);

        run_block("abc_junkst", 1'b0, 0, 5, 30, -1, -1);
        run_block("abc_abort", 1'b0, 0, -1, -1, 30, -1);
        run_block("abc_after", 1'b0, 0, -1, -1, -1, -1);
        cur_blk = "after_consts";
        check("W63", got_w[63], 32'h12B1EDEB);

        run_block("abc_r20", 1'b1, 0, -1, -1, -1, -1);
        cur_blk = "r20_consts";
        check("W16", got_w[16], 32'h61626380);
        check("W17", got_w[17], 32'h000F0000);

        for (int k = 0; k < 6; k++) begin
            load_random();
            run_block($sformatf("rand%0d", k), 1'(k % 2), 2,
                      int'($urandom_range(2, 10)), -1, -1, -1);
        end

        load_random();
        run_block("rand_rst", 1'b0, 0, -1, -1, -1, 40);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur_blk = "post_reset";
        for (int c = 0; c < 4; c++) begin
            word_valid = 1'b1;
            word_i = $urandom;
            @(negedge clk);
            cur_cyc = c;
            check("ready",   32'(ready64), 32'h0);
            check("busy",    32'(busy64),  32'h0);
            check("w_valid", 32'(valid64), 32'h0);
        end
        word_valid = 1'b0;

        load_random();
        run_block("rand_final", 1'b0, 2, -1, -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
